i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 30, clk cycles per SCL quarter-period; legal range 1..255; SCL period = 4*CLK_DIV cycles.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  transaction request, sampled only in IDLE.
REQ-005 SHALL have port rw  input  1  0 = register write, 1 = register read.
REQ-006 SHALL have port dev_addr  input  7  target 7-bit device address.
REQ-007 SHALL have port reg_addr  input  8  target register address.
REQ-008 SHALL have port wdata  input  8  write data byte.
REQ-009 SHALL have port rdata  output  8  last read byte.
REQ-010 SHALL have port busy  output  1  transaction in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port ack_err  output  1  NACK seen in last transaction; valid while done=1 and held until next accepted start.
REQ-013 SHALL have port scl_o  output  1  SCL drive, 1 = released/high.
REQ-014 SHALL have port sda_i  input  1  SDA line sample.
REQ-015 SHALL have port sda_o  output  1  SDA drive, 0 = pull low, 1 = release.

Function
REQ-016 SHALL accept start=1 only in IDLE: latch rw, dev_addr, reg_addr, wdata; clear ack_err; busy=1 from the next cycle; start while busy SHALL be ignored.
REQ-017 SHALL time all line activity in slots of 4 quarters, each quarter exactly CLK_DIV cycles from a free-running-while-busy divider reset at accept.
REQ-018 SHALL run data/ACK bit slots as: q0 SCL low, SDA updated at q0 start; q1,q2 SCL high; q3 SCL low; sda_i sampled on the last cycle of q1.
REQ-019 SHALL run START slot as: q0 SDA=1 SCL=1; q1 SDA=1 SCL=1; q2 SDA=0 SCL=1; q3 SDA=0 SCL=0.
REQ-020 SHALL run repeated-START slot as: q0 SDA=1 SCL=0; q1 SDA=1 SCL=1; q2 SDA=0 SCL=1; q3 SDA=0 SCL=0.
REQ-021 SHALL run STOP slot as: q0 SDA=0 SCL=0; q1 SDA=0 SCL=1; q2,q3 SDA=1 SCL=1.
REQ-022 SHALL send bytes MSB first; address byte = {dev_addr, R/W bit}.
REQ-023 SHALL sequence write as: IDLE, START, ADDR(W=0), ACK, REG, ACK, DATA, ACK, STOP = 29 slots.
REQ-024 SHALL sequence read as: IDLE, START, ADDR(W=0), ACK, REG, ACK, RSTART, ADDR(R=1), ACK, RDATA, master NACK (SDA=1), STOP = 39 slots.
REQ-025 SHALL release SDA (sda_o=1) during every ACK slot and every RDATA bit; SHALL shift sda_i into rdata during RDATA and update rdata output at end of RDATA.
REQ-026 SHALL treat sda_i=1 at an ACK sample as NACK: set ack_err=1, go directly to STOP after that ACK slot, skip remaining bytes, leave rdata unchanged.
REQ-027 SHALL keep busy=1 for exactly (slots*4*CLK_DIV) cycles; on the final cycle of STOP q3, next cycle busy=0, done=1 for one cycle, state IDLE.
REQ-028 SHALL accept a new start in the same cycle done=1 (back-to-back allowed).
REQ-029 SHALL not support clock stretching or arbitration; SCL is driven without reading back.
REQ-030 SHALL hold scl_o=1, sda_o=1 in IDLE.

Reset
REQ-031 SHALL on reset=1, at any time including mid-transaction, immediately force scl_o=1, sda_o=1, busy=0, done=0, ack_err=0, rdata=8'h00, state IDLE, divider and bit counters 0.
REQ-032 SHALL begin normal operation on the first rising clk edge after reset deasserts; no bus STOP issued for an aborted transaction.

Verification
REQ-033 Write, CLK_DIV=2, dev 0x4A, reg 0x03, wdata 0xA5, slave ACKs all -> bytes 0x94,0x03,0xA5 on SDA sampled at SCL rise, busy high 232 cycles, done pulse, ack_err=0.
REQ-034 Read, CLK_DIV=2, dev 0x4A, reg 0x10, slave returns 0x5C -> bytes 0x94,0x10, repeated START, 0x95, master NACK, STOP; rdata=0x5C, busy 312 cycles, ack_err=0.
REQ-035 Write to absent device (sda_i held 1) -> NACK at first ACK, STOP follows, busy 44*CLK_DIV cycles, ack_err=1, done pulse.
REQ-036 start pulsed while busy -> ignored, in-flight bytes unchanged; start asserted in done cycle -> second transaction begins, busy low for exactly one cycle.
REQ-037 reset asserted mid-DATA byte -> same cycle scl_o=1, sda_o=1, busy=0; new write after release completes normally.
REQ-038 START/STOP checks: SDA changes only while SCL low except START/RSTART (high->low) and STOP (low->high) with SCL high.

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte I2C register-access master (write or read) with a fixed SCL rate
// of 4*CLK_DIV clk cycles per bit slot; the bus is driven without readback.
module i2c_master #(
  parameter int CLK_DIV = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_REG, S_WDATA, S_RSTART, S_RADDR, S_RDATA, S_STOP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] qtr_q, qtr_d;
  logic [7:0] div_q, div_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_err_q, ack_err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;

  logic       qtr_end_s, slot_end_s, sample_s, ack_slot_s;
  logic [7:0] tx_byte_s;

  // Sequencing, sampling and line levels; line levels are derived from the next state so they register in step with it
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    qtr_d      = qtr_q;
    div_d      = div_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    ack_err_d  = ack_err_q;
    done_d     = 1'b0;
    qtr_end_s  = (div_q == DIV_LAST);
    slot_end_s = qtr_end_s && (qtr_q == 2'd3);
    sample_s   = qtr_end_s && (qtr_q == 2'd1);
    ack_slot_s = (bit_q == 4'd8);

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d   = S_START;
        rw_d      = rw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        wdata_d   = wdata;
        ack_err_d = 1'b0;
        div_d     = 8'd0;
        qtr_d     = 2'd0;
        bit_d     = 4'd0;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      div_d = qtr_end_s ? 8'd0 : div_q + 8'd1;
      qtr_d = qtr_end_s ? qtr_q + 2'd1 : qtr_q;
      if (sample_s && ack_slot_s && (state_q inside {S_ADDR, S_REG, S_WDATA, S_RADDR})) begin
        ack_err_d = ack_err_q | sda_i;
      end else if (sample_s && !ack_slot_s && (state_q == S_RDATA)) begin
        shift_d = {shift_q[6:0], sda_i};
      end else begin
        shift_d = shift_q;
      end

      if (slot_end_s) begin
        bit_d = bit_q + 4'd1;
        case (state_q)
          S_START:  begin state_d = S_ADDR;  bit_d = 4'd0; end
          S_RSTART: begin state_d = S_RADDR; bit_d = 4'd0; end
          S_STOP:   begin state_d = S_IDLE;  bit_d = 4'd0; done_d = 1'b1; end
          S_RDATA: begin
            if (bit_q == 4'd7) rdata_d = shift_q;
            else rdata_d = rdata_q;
            if (ack_slot_s) begin state_d = S_STOP; bit_d = 4'd0; end
            else state_d = S_RDATA;
          end
          default: begin
            if (ack_slot_s) begin
              bit_d = 4'd0;
              // A NACK on any slave ACK abandons the rest of the frame
              if (ack_err_q) begin
                state_d = S_STOP;
              end else begin
                case (state_q)
                  S_ADDR:  state_d = S_REG;
                  S_REG:   state_d = rw_q ? S_RSTART : S_WDATA;
                  S_RADDR: state_d = S_RDATA;
                  default: state_d = S_STOP;
                endcase
              end
            end else begin
              state_d = state_q;
            end
          end
        endcase
      end else begin
        bit_d = bit_q;
      end
    end

    case (state_d)
      S_ADDR:  tx_byte_s = {dev_q, 1'b0};
      S_REG:   tx_byte_s = reg_q;
      S_WDATA: tx_byte_s = wdata_q;
      S_RADDR: tx_byte_s = {dev_q, 1'b1};
      default: tx_byte_s = 8'hFF;
    endcase

    case (state_d)
      S_IDLE:   begin scl_d = 1'b1;              sda_d = 1'b1; end
      S_START:  begin scl_d = (qtr_d != 2'd3);   sda_d = ~qtr_d[1]; end
      S_RSTART: begin scl_d = (qtr_d[1] ^ qtr_d[0]); sda_d = ~qtr_d[1]; end
      S_STOP:   begin scl_d = (qtr_d != 2'd0);   sda_d = qtr_d[1]; end
      default: begin
        scl_d = (qtr_d[1] ^ qtr_d[0]);
        sda_d = (bit_d == 4'd8) ? 1'b1 : tx_byte_s[3'd7 - bit_d[2:0]];
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset releases both bus lines at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_q     <= 4'd0;
      qtr_q     <= 2'd0;
      div_q     <= 8'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wdata_q   <= 8'd0;
      shift_q   <= 8'd0;
      rdata_q   <= 8'd0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      qtr_q     <= qtr_d;
      div_q     <= div_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl_o   = scl_q;
  assign sda_o   = sda_q;

endmodule

// File: tb/tb_i2c_master.sv
// Randomised bench for i2c_master: a bus-level slave decodes SDA/SCL into an
// event log that is compared with a frame list built from the protocol rules.
module tb_i2c_master;
  localparam int DIV = 2;
  localparam int EV_S = 256, EV_P = 257, EV_ACK = 512;

  logic clk = 1'b0;
  logic reset, start, rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wdata, rdata;
  logic busy, done, ack_err, scl_o, sda_i, sda_o;
  logic slave_sda;

  int n_checks = 0, n_fail = 0;

  // bus slave model state
  int k, byte_no, rcv_no, nack_at, bus_err;
  logic [7:0] rx, slave_tx_byte;
  bit slv_tx, tx_next;
  logic prev_scl, prev_sda;
  int ev_log[$];

  // reference expectations
  int exp_ev[$];
  int exp_slots;
  logic exp_ack;
  logic [7:0] exp_rdata;

  assign sda_i = sda_o & slave_sda;

  i2c_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .ack_err(ack_err), .scl_o(scl_o), .sda_i(sda_i), .sda_o(sda_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Slave: watches the wires on the falling clk edge, logs START/STOP/bytes/ACKs and answers
  always @(negedge clk) begin
    if (reset) begin
      k = 0; byte_no = 0; slv_tx = 0; slave_sda = 1'b1;
      prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if ((scl_o != prev_scl) && (sda_i != prev_sda)) bus_err++;
      if (prev_scl && scl_o && (sda_i != prev_sda)) begin
        if (!sda_i) begin
          ev_log.push_back(EV_S);
          k = 0; byte_no = 0; slv_tx = 0; slave_sda = 1'b1;
        end else begin
          ev_log.push_back(EV_P);
        end
      end else if (!prev_scl && scl_o) begin
        if (k < 8) begin
          rx = {rx[6:0], sda_i};
          if (k == 7) ev_log.push_back(int'(rx));
          k++;
        end else begin
          ev_log.push_back(EV_ACK + int'(sda_i));
          tx_next = !slv_tx && (byte_no == 0) && rx[0] && !sda_i;
          slv_tx = tx_next;
          byte_no++;
          k = 0;
        end
      end else if (prev_scl && !scl_o) begin
        if (k == 8) begin
          if (slv_tx) slave_sda = 1'b1;
          else begin
            slave_sda = (rcv_no == nack_at) ? 1'b1 : 1'b0;
            rcv_no++;
          end
        end else if (slv_tx) slave_sda = slave_tx_byte[7 - k];
        else slave_sda = 1'b1;
      end
      prev_scl = scl_o;
      prev_sda = sda_i;
    end
  end

  // Frame list from the protocol rules: bytes, ACK levels, slot count
  task automatic build_expect(input logic rw_i, input logic [6:0] dev, input logic [7:0] rg,
                              input logic [7:0] wd, input logic [7:0] rb, input int nk);
    logic [7:0] mb[3];
    bit nacked;
    nacked = 0;
    exp_ev.delete();
    exp_ev.push_back(EV_S);
    exp_slots = 1;
    mb[0] = {dev, 1'b0};
    mb[1] = rg;
    mb[2] = rw_i ? {dev, 1'b1} : wd;
    for (int i = 0; i < 3; i++) begin
      if (rw_i && i == 2) begin exp_ev.push_back(EV_S); exp_slots++; end
      exp_ev.push_back(int'(mb[i]));
      exp_ev.push_back(EV_ACK + ((i == nk) ? 1 : 0));
      exp_slots += 9;
      if (i == nk) begin nacked = 1; break; end
    end
    if (rw_i && !nacked) begin
      exp_ev.push_back(int'(rb));
      exp_ev.push_back(EV_ACK + 1);
      exp_slots += 9;
      exp_rdata = rb;
    end
    exp_ev.push_back(EV_P);
    exp_slots++;
    exp_ack = nacked;
  endtask

  task automatic do_txn(input logic rw_i, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input logic [7:0] rb, input int nk,
                        input bit b2b, input bit glitch);
    int cnt, glitch_at, n;
    bit seen;
    if (!b2b) repeat (3) @(negedge clk);
    build_expect(rw_i, dev, rg, wd, rb, nk);
    rw = rw_i; dev_addr = dev; reg_addr = rg; wdata = wd;
    slave_tx_byte = rb; nack_at = nk; rcv_no = 0;
    ev_log.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_accept", busy, 1'b1);
    check_eq("done_one_cycle", done, 1'b0);
    glitch_at = glitch ? 10 + $urandom_range(0, exp_slots * 4 * DIV - 30) : -5;
    cnt = 0; seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin seen = 1; break; end
      if (busy) cnt++;
      if (c == glitch_at) begin
        start = 1'b1; rw = ~rw_i; dev_addr = 7'($urandom); reg_addr = 8'($urandom); wdata = 8'($urandom);
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("done_seen", seen, 1'b1);
    check_eq("busy_cycles", cnt, exp_slots * 4 * DIV);
    check_eq("busy_low_at_done", busy, 1'b0);
    check_eq("ack_err", ack_err, exp_ack);
    check_eq("rdata", rdata, exp_rdata);
    check_eq("bus_rule", bus_err, 0);
    check_eq("ev_count", ev_log.size(), exp_ev.size());
    n = (ev_log.size() < exp_ev.size()) ? ev_log.size() : exp_ev.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("ev[%0d]", i), ev_log[i], exp_ev[i]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = 7'd0; reg_addr = 8'd0; wdata = 8'd0;
    slave_sda = 1'b1; nack_at = 9; rcv_no = 0; bus_err = 0; rx = 8'd0; slave_tx_byte = 8'd0;
    exp_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_scl", scl_o, 1'b1);
    check_eq("rst_sda", sda_o, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ack_err", ack_err, 1'b0);
    check_eq("rst_rdata", rdata, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    bus_err = 0;

    do_txn(1'b0, 7'h4A, 8'h03, 8'hA5, 8'h00, 9, 1'b0, 1'b0);
    do_txn(1'b1, 7'h4A, 8'h10, 8'h00, 8'h5C, 9, 1'b0, 1'b0);
    do_txn(1'b0, 7'h4A, 8'h03, 8'hA5, 8'h00, 0, 1'b0, 1'b0);
    do_txn(1'b1, 7'h2B, 8'h81, 8'h00, 8'hC3, 9, 1'b1, 1'b1);

    for (int t = 0; t < 16; t++) begin
      do_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 9,
             1'($urandom), 1'($urandom));
    end

    // abort a write in the middle of its data byte
    repeat (3) @(negedge clk);
    rw = 1'b0; dev_addr = 7'h11; reg_addr = 8'h22; wdata = 8'h33; nack_at = 9; rcv_no = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8 * 22) @(negedge clk);
    check_eq("pre_abort_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("abort_scl", scl_o, 1'b1);
    check_eq("abort_sda", sda_o, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rdata = 8'h00;
    repeat (2) @(negedge clk);
    bus_err = 0;
    do_txn(1'b0, 7'h4A, 8'h03, 8'hA5, 8'h00, 9, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
